// File: rtl/uart_tx_arbiter_if.sv
// Client-lane and transmitter handshake bundle for the UART TX arbiter.
// The master view belongs to the arbiter; the slave view is the surrounding
// logic (clients plus the transmitter).
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               err_timeout;

    modport master (
        input  req, req_data, req_last, tx_done,
        output ack, grant, tx_data, tx_start, err_timeout
    );

    modport slave (
        output req, req_data, req_last, tx_done,
        input  ack, grant, tx_data, tx_start, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among N_REQ byte-stream
// clients. One client owns the transmitter per packet (or per burst of up to
// MAX_BURST bytes); each byte is held until the transmitter has taken it and
// finished it. tx_done comes from the divided bit-clock domain and is
// resynchronised before use.
//
// state | meaning
// IDLE  | no owner; arbitrate once the transmitter reports idle
// LOAD  | latch the owner's byte and last flag, raise tx_start
// START | hold tx_start until the transmitter goes busy (or time out)
// BUSY  | wait for the transmitter to finish, then continue or release
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int START_TO  = 20000
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = $clog2(START_TO + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, BUSY} state_t;

    state_t           state_q;
    logic             done_meta_q;
    logic             done_sync_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gidx_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ack_q;
    logic [7:0]       burst_q;
    logic [7:0]       tx_data_q;
    logic [TO_W-1:0]  to_q;
    logic             last_q;
    logic             tx_start_q;
    logic             err_q;

    logic             sel_valid_d;
    logic [IDX_W-1:0] sel_idx_d;
    logic [IDX_W-1:0] next_idx_d;

    // Two-flop synchroniser for the transmitter's idle/busy level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
        end else begin
            done_meta_q <= bus.tx_done;
            done_sync_q <= done_meta_q;
        end
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_valid_d = 1'b0;
        sel_idx_d   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand     = (int'(ptr_q) + i) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!sel_valid_d && bus.req[cand_idx]) begin
                sel_valid_d = 1'b1;
                sel_idx_d   = cand_idx;
            end
        end
    end

    // Pointer value that puts the current owner at lowest priority.
    always_comb begin
        next_idx_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end

    // Sequencer: grant, per-byte start/done handshake, burst and timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            burst_q    <= '0;
            tx_data_q  <= '0;
            to_q       <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (sel_valid_d && done_sync_q) begin
                        gidx_q  <= sel_idx_d;
                        grant_q <= N_REQ'(1) << sel_idx_d;
                        burst_q <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data_q  <= bus.req_data[{gidx_q, 3'b000} +: 8];
                    last_q     <= bus.req_last[gidx_q];
                    tx_start_q <= 1'b1;
                    to_q       <= '0;
                    state_q    <= START;
                end
                START: begin
                    if (!done_sync_q) begin
                        tx_start_q <= 1'b0;
                        ack_q      <= grant_q;
                        if (burst_q < 8'(MAX_BURST)) begin
                            burst_q <= burst_q + 1'b1;
                        end
                        state_q <= BUSY;
                    end else if (to_q == TO_W'(START_TO - 1)) begin
                        tx_start_q <= 1'b0;
                        err_q      <= 1'b1;
                        grant_q    <= '0;
                        ptr_q      <= next_idx_d;
                        state_q    <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                BUSY: begin
                    if (done_sync_q) begin
                        // A dropped request mid-packet releases like a last byte.
                        if (last_q || (burst_q == 8'(MAX_BURST)) || !bus.req[gidx_q]) begin
                            grant_q <= '0;
                            ptr_q   <= next_idx_d;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant       = grant_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four client lanes fed from byte queues,
// a transmitter model (tx_done falls 5 cycles after tx_start, rises 40 later),
// and a monitor logging acks, accepted bytes and grant owners.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(4)) bus ();

    uart_tx_arbiter #(
        .N_REQ    (4),
        .MAX_BURST(16),
        .START_TO (50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [8:0] lane_q [4][$];
    int         ack_log[$];
    logic [7:0] data_log[$];
    logic [3:0] grant_log[$];
    logic       tx_dead      = 1'b0;
    int         start_hi     = 0;
    int         start_rise   = 0;
    logic       prev_start   = 1'b0;
    logic [3:0] prev_grant   = '0;
    logic       err_seen     = 1'b0;
    int         hi_at_err    = 0;
    int         acks_at_err  = 0;
    logic [3:0] grant_at_err = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (ack_log.size() < n && c < budget) begin
            cycles(1);
            c++;
        end
        chk(tag, 32'(ack_log.size() >= n), 32'd1);
    endtask

    task automatic wait_grant_zero(input int budget, input string tag);
        int c;
        c = 0;
        while (bus.grant != 4'b0000 && c < budget) begin
            cycles(1);
            c++;
        end
        chk(tag, 32'(bus.grant), 32'd0);
    endtask

    task automatic do_reset();
        int c;
        cycles(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) lane_q[i].delete();
        tx_dead = 1'b0;
        ack_log.delete();
        data_log.delete();
        grant_log.delete();
        start_hi   = 0;
        start_rise = 0;
        err_seen   = 1'b0;
        cycles(3);
        c = 0;
        while (!bus.tx_done && c < 100) begin
            cycles(1);
            c++;
        end
        rst = 1'b1;
    endtask

    // Client lanes: pop on ack, present the queue head.
    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i] && lane_q[i].size() > 0) lane_q[i].delete(0);
                if (lane_q[i].size() > 0) begin
                    bus.req[i]           = 1'b1;
                    bus.req_data[8*i +: 8] = lane_q[i][0][7:0];
                    bus.req_last[i]      = lane_q[i][0][8];
                end else begin
                    bus.req[i]           = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_last[i]      = 1'b0;
                end
            end
        end
    end

    // Transmitter model.
    initial begin
        bus.tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_start && !tx_dead) begin
                repeat (5) @(negedge clk);
                bus.tx_done = 1'b0;
                repeat (40) @(negedge clk);
                bus.tx_done = 1'b1;
            end
        end
    end

    // Monitor.
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (bus.tx_start) start_hi++;
            if (bus.tx_start && !prev_start) start_rise++;
            prev_start = bus.tx_start;
            if (bus.ack != 4'b0000) begin
                chk("ack_matches_grant", 32'(bus.ack), 32'(bus.grant));
                idx = 0;
                for (int i = 0; i < 4; i++) if (bus.ack[i]) idx = i;
                ack_log.push_back(idx);
                data_log.push_back(bus.tx_data);
            end
            if (bus.grant != prev_grant && bus.grant != 4'b0000) grant_log.push_back(bus.grant);
            prev_grant = bus.grant;
            if (bus.err_timeout && !err_seen) begin
                err_seen     = 1'b1;
                hi_at_err    = start_hi;
                acks_at_err  = ack_log.size();
                grant_at_err = bus.grant;
            end
        end
    end

    initial begin
        int c;
        int exp_client;
        logic [7:0] exp_data;

        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_grant",    32'(bus.grant),       32'd0);
        chk("rst_ack",      32'(bus.ack),         32'd0);
        chk("rst_tx_start", 32'(bus.tx_start),    32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),     32'h00);
        chk("rst_err",      32'(bus.err_timeout), 32'd0);
        cycles(3);
        rst = 1'b1;

        // Single client 1, three bytes.
        lane_q[1].push_back({1'b0, 8'h41});
        lane_q[1].push_back({1'b0, 8'h42});
        lane_q[1].push_back({1'b1, 8'h43});
        wait_acks(3, 400, "t1_acks_seen");
        chk("t1_ack0_client", 32'(ack_log[0]), 32'd1);
        chk("t1_ack1_client", 32'(ack_log[1]), 32'd1);
        chk("t1_ack2_client", 32'(ack_log[2]), 32'd1);
        chk("t1_data0", 32'(data_log[0]), 32'h41);
        chk("t1_data1", 32'(data_log[1]), 32'h42);
        chk("t1_data2", 32'(data_log[2]), 32'h43);
        chk("t1_grant_busy", 32'(bus.grant), 32'h2);
        c = 0;
        while (!bus.tx_done && c < 100) begin
            cycles(1);
            c++;
        end
        chk("t1_grant_at_done_rise", 32'(bus.grant), 32'h2);
        cycles(4);
        chk("t1_grant_released", 32'(bus.grant), 32'd0);
        chk("t1_single_grant", 32'(grant_log.size()), 32'd1);

        // Clients 0, 2, 3 together; client 0 repeats during client 2's service.
        do_reset();
        lane_q[0].push_back({1'b1, 8'hA0});
        lane_q[2].push_back({1'b1, 8'hA2});
        lane_q[3].push_back({1'b1, 8'hA3});
        wait_acks(2, 300, "t2_first_two");
        lane_q[0].push_back({1'b1, 8'hB0});
        wait_acks(4, 400, "t2_all_four");
        chk("t2_order0", 32'(ack_log[0]), 32'd0);
        chk("t2_order1", 32'(ack_log[1]), 32'd2);
        chk("t2_order2", 32'(ack_log[2]), 32'd3);
        chk("t2_order3", 32'(ack_log[3]), 32'd0);
        chk("t2_repeat_data", 32'(data_log[3]), 32'hB0);

        // Client 0 streams 20 bytes, client 1 waiting: burst limit 16.
        do_reset();
        for (int b = 0; b < 20; b++) lane_q[0].push_back({1'b0, 8'(b)});
        lane_q[1].push_back({1'b1, 8'hA1});
        wait_acks(21, 3000, "t3_all_acks");
        for (int k = 0; k < 21; k++) begin
            exp_client = (k == 16) ? 1 : 0;
            exp_data   = (k < 16) ? 8'(k) : ((k == 16) ? 8'hA1 : 8'(k - 1));
            chk("t3_ack_client", 32'(ack_log[k]), 32'(exp_client));
            chk("t3_ack_data", 32'(data_log[k]), 32'(exp_data));
        end
        chk("t3_grant_count", 32'(grant_log.size()), 32'd3);
        chk("t3_grant_first",  32'(grant_log[0]), 32'h1);
        chk("t3_grant_second", 32'(grant_log[1]), 32'h2);
        chk("t3_grant_third",  32'(grant_log[2]), 32'h1);
        wait_grant_zero(200, "t3_final_release");

        // Transmitter never goes busy: start timeout.
        do_reset();
        tx_dead = 1'b1;
        lane_q[2].push_back({1'b1, 8'h55});
        c = 0;
        while (!err_seen && c < 300) begin
            cycles(1);
            c++;
        end
        chk("t4_err_seen", 32'(err_seen), 32'd1);
        chk("t4_start_cycles", 32'(hi_at_err), 32'd50);
        chk("t4_no_ack", 32'(acks_at_err), 32'd0);
        chk("t4_grant_cleared", 32'(grant_at_err), 32'd0);
        chk("t4_err_out", 32'(bus.err_timeout), 32'd1);
        lane_q[2].delete();
        do_reset();
        chk("t4_err_after_reset", 32'(bus.err_timeout), 32'd0);

        // Reset while client 1 is in BUSY; pointer must restart at 0.
        lane_q[2].push_back({1'b1, 8'hC2});
        wait_acks(1, 200, "t5_client2_ack");
        lane_q[1].push_back({1'b1, 8'h99});
        wait_acks(2, 300, "t5_client1_ack");
        cycles(5);
        chk("t5_grant_busy", 32'(bus.grant), 32'h2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) lane_q[i].delete();
        #1;
        chk("t5_rst_grant",    32'(bus.grant),       32'd0);
        chk("t5_rst_ack",      32'(bus.ack),         32'd0);
        chk("t5_rst_tx_start", 32'(bus.tx_start),    32'd0);
        chk("t5_rst_tx_data",  32'(bus.tx_data),     32'h00);
        chk("t5_rst_err",      32'(bus.err_timeout), 32'd0);
        cycles(3);
        rst = 1'b1;
        cycles(10);
        chk("t5_no_extra_ack", 32'(ack_log.size()), 32'd2);
        grant_log.delete();
        lane_q[0].push_back({1'b1, 8'hD0});
        lane_q[3].push_back({1'b1, 8'hD3});
        wait_acks(4, 400, "t5_post_reset_acks");
        chk("t5_first_grant", 32'(grant_log[0]), 32'h1);
        chk("t5_order0", 32'(ack_log[2]), 32'd0);
        chk("t5_order1", 32'(ack_log[3]), 32'd3);

        // Client 1 drops req after the first byte of a two-byte packet.
        do_reset();
        lane_q[1].push_back({1'b0, 8'h77});
        wait_acks(1, 200, "t6_first_ack");
        chk("t6_grant_held", 32'(bus.grant), 32'h2);
        wait_grant_zero(200, "t6_release");
        cycles(60);
        chk("t6_single_start", 32'(start_rise), 32'd1);
        chk("t6_single_ack", 32'(ack_log.size()), 32'd1);
        chk("t6_tx_start_low", 32'(bus.tx_start), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ byte-stream clients.
- Grants one client at a time for a packet (or burst), and hands its bytes one at a time to the transmitter over the start/done handshake.
- Holds each byte stable until the transmitter, running on its divided bit clock, has accepted and finished it.
- Sits between client logic and the transmitter in the UART top level.

Parameters:
- N_REQ, 4, number of requesting clients (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255).
- START_TO, 20000, clk cycles allowed for the transmitter's tx_done to fall after tx_start is asserted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-client request; a byte is valid on that client's lane.
- req_data  in  8*N_REQ  per-client byte; client i uses bits [8i+7:8i].
- req_last  in  N_REQ  per-client flag: this byte ends the packet.
- ack  out  N_REQ  one-cycle pulse; the granted client's current byte was accepted by the transmitter.
- grant  out  N_REQ  one-hot, current owner; all zero when idle.
- tx_data  out  8  byte driven to the transmitter.
- tx_start  out  1  start request to the transmitter.
- tx_done  in  1  transmitter level: 1 = idle/ready, 0 = busy.
- err_timeout  out  1  sticky; the transmitter failed to start within START_TO. Cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous) forces these values:
  - state=IDLE, grant=0, ack=0, tx_start=0, tx_data=8'h00, err_timeout=0.
  - Round-robin pointer = 0, so client 0 has highest priority first.
  - Burst count=0, timeout counter=0.
  - Reset mid-byte abandons the byte; no ack is issued.
- Every tx_done sample passes through a 2-flop synchronizer before use. All tx_done references below mean the synchronized value.
- IDLE:
  - Stays in IDLE if req=0, or if the synchronized tx_done=0.
  - Otherwise selects the first requester at or after the pointer, wrapping modulo N_REQ.
  - Sets grant one-hot, clears burst count, and moves to LOAD next cycle.
  - Arbitration takes exactly 1 cycle.
- LOAD:
  - Latches req_data and req_last of the granted lane into tx_data and a last flag.
  - Asserts tx_start=1, clears the timeout counter, and moves to START.
- START:
  - Holds tx_start=1 and tx_data stable.
  - On tx_done=0 (transmitter accepted): deasserts tx_start, pulses ack for the granted lane for 1 cycle, increments burst count, and moves to BUSY.
  - Otherwise increments the timeout counter.
  - When the counter reaches START_TO-1: drops tx_start, sets err_timeout, clears grant, and returns to IDLE with no ack.
  - On timeout the pointer advances past the failed client.
- BUSY: waits for tx_done=1, then decides:
  - If the last flag is set, or burst count==MAX_BURST: clear grant, set pointer = granted index + 1 (mod N_REQ), go to IDLE.
  - Else if the granted client's req=1: go to LOAD (next byte, same owner).
  - Else (client dropped req mid-packet): release as for last, go to IDLE.
- Clients must hold req/req_data/req_last stable until they see ack. After ack they may present the next byte or drop req.
- At most one ack bit is high in any cycle, always matching grant. grant never changes outside IDLE and release.
- Burst count is 8 bits and saturates at MAX_BURST; it never wraps.
- Simultaneous requests resolve by round-robin. A client requesting during another's grant waits until release.
- tx_done=0 in IDLE (transmitter still busy from an earlier byte) blocks arbitration.

Test Plan:
- Single client 1 sends 3 bytes 8'h41, 8'h42, 8'h43 (last on the third), with a transmitter model whose tx_done falls 5 cycles after tx_start and rises 40 cycles later:
  - grant=4'b0010 throughout; 3 ack pulses; tx_data sequence 41, 42, 43.
  - grant=0 after the third byte's tx_done rises.
- Clients 0, 2, 3 request simultaneously with 1-byte packets after reset:
  - Service order is 0, 2, 3.
  - A repeat request from client 0 during service of 2 is served after 3.
- Client 0 streams 20 bytes without last, MAX_BURST=16, client 1 requesting:
  - Release after byte 16; client 1 is granted next; client 0 resumes afterwards.
- Transmitter model never drops tx_done, START_TO=50:
  - tx_start high for exactly 50 cycles; err_timeout=1; no ack; grant clears.
- Assert rst=0 while in BUSY:
  - All outputs return to reset values immediately; no ack.
  - After release, client 0 is granted first.
- Granted client drops req after its first ack in a 2-byte packet:
  - The arbiter releases after tx_done rises; no further tx_start is issued.
